// File: rtl/chip8_fetch.sv
// ============================================================================
// Module   : chip8_fetch
// Purpose  : CHIP-8 instruction fetch; reads two RAM bytes at PC, PC+1 and
//            presents them big-endian as one 16-bit opcode with a valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chip8_fetch #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o,
    output logic [15:0]       opcode_o,
    output logic [ADDR_W-1:0] opcode_pc_o,
    output logic              opcode_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RD_HI    = 2'd1,
        S_RD_LO    = 2'd2,
        S_ASSEMBLE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [7:0]          hi_q, hi_d;
    logic [15:0]         opcode_q, opcode_d;
    logic [ADDR_W-1:0]   opcode_pc_q, opcode_pc_d;
    logic                valid_q, valid_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            hi_q        <= 8'h00;
            opcode_q    <= 16'h0000;
            opcode_pc_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hi_q        <= hi_d;
            opcode_q    <= opcode_d;
            opcode_pc_q <= opcode_pc_d;
            valid_q     <= valid_d;
        end
    end

    // RAM strobe/address are decoded from registered state only; outside
    // the two read cycles the address rests on pc_q so it stays stable.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hi_d        = hi_q;
        opcode_d    = opcode_q;
        opcode_pc_d = opcode_pc_q;
        valid_d     = 1'b0;
        mem_rd_o    = 1'b0;
        mem_addr_o  = pc_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_req_i) begin
                    pc_d    = pc_i;
                    state_d = S_RD_HI;
                end
            end
            S_RD_HI: begin
                mem_rd_o = 1'b1;
                state_d  = S_RD_LO;
            end
            S_RD_LO: begin
                hi_d       = mem_rdata_i;
                mem_rd_o   = 1'b1;
                mem_addr_o = pc_q + C_ONE;
                state_d    = S_ASSEMBLE;
            end
            S_ASSEMBLE: begin
                opcode_d    = {hi_q, mem_rdata_i};
                opcode_pc_d = pc_q;
                valid_d     = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o         = (state_q != S_IDLE);
    assign opcode_o       = opcode_q;
    assign opcode_pc_o    = opcode_pc_q;
    assign opcode_valid_o = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_chip8_fetch.sv
// ============================================================================
// Module   : tb_chip8_fetch
// Purpose  : Self-checking bench for chip8_fetch with a byte-wide RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chip8_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [11:0] pc;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic [15:0] opcode;
    logic [11:0] opcode_pc;
    logic        opcode_valid;

    logic [7:0]  ram [4096];

    int total = 0;
    int bad   = 0;

    chip8_fetch #(.ADDR_W(12)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .fetch_req_i    (fetch_req),
        .pc_i           (pc),
        .mem_rd_o       (mem_rd),
        .mem_addr_o     (mem_addr),
        .mem_rdata_i    (mem_rdata),
        .busy_o         (busy),
        .opcode_o       (opcode),
        .opcode_pc_o    (opcode_pc),
        .opcode_valid_o (opcode_valid)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears one cycle after the strobe cycle.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic [11:0] pc;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_op;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch with per-cycle checks; called just after an edge, DUT idle.
    task automatic run_fetch(input logic [11:0] a, input logic [15:0] exp_op);
        logic [11:0] a1;
        a1 = a + 12'd1;
        fetch_req = 1'b1;
        pc        = a;
        tick();
        fetch_req = 1'b0;
        pc        = 12'hABC;
        chk("rdhi_busy",  {31'd0, busy},   32'd1);
        chk("rdhi_rd",    {31'd0, mem_rd}, 32'd1);
        chk("rdhi_addr",  {20'd0, mem_addr}, {20'd0, a});
        tick();
        chk("rdlo_rd",    {31'd0, mem_rd}, 32'd1);
        chk("rdlo_addr",  {20'd0, mem_addr}, {20'd0, a1});
        tick();
        chk("asm_rd",     {31'd0, mem_rd}, 32'd0);
        chk("asm_busy",   {31'd0, busy},   32'd1);
        chk("asm_valid",  {31'd0, opcode_valid}, 32'd0);
        tick();
        chk("done_valid", {31'd0, opcode_valid}, 32'd1);
        chk("done_op",    {16'd0, opcode}, {16'd0, exp_op});
        chk("done_pc",    {20'd0, opcode_pc}, {20'd0, a});
        chk("done_busy",  {31'd0, busy}, 32'd0);
        tick();
        chk("post_valid", {31'd0, opcode_valid}, 32'd0);
        chk("post_op",    {16'd0, opcode}, {16'd0, exp_op});
    endtask

    initial begin
        int vcount;
        int t_first;
        int t_second;
        int seen;
        logic saw_400;

        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        mem_rdata = 8'h00;

        vecs[0] = '{pc: 12'h200, hi: 8'h6A, lo: 8'h2F, exp_op: 16'h6A2F};
        vecs[1] = '{pc: 12'hFFF, hi: 8'h00, lo: 8'hE0, exp_op: 16'h00E0};
        vecs[2] = '{pc: 12'h205, hi: 8'hF2, lo: 8'h33, exp_op: 16'hF233};
        vecs[3] = '{pc: 12'h000, hi: 8'h12, lo: 8'h34, exp_op: 16'h1234};
        vecs[4] = '{pc: 12'h7FE, hi: 8'hAB, lo: 8'hCD, exp_op: 16'hABCD};

        reset     = 1'b1;
        fetch_req = 1'b0;
        pc        = 12'h000;
        tick();
        tick();
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_rd",     {31'd0, mem_rd}, 32'd0);
        chk("rst_addr",   {20'd0, mem_addr}, 32'd0);
        chk("rst_op",     {16'd0, opcode}, 32'd0);
        chk("rst_oppc",   {20'd0, opcode_pc}, 32'd0);
        chk("rst_valid",  {31'd0, opcode_valid}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            ram[vecs[i].pc]         = vecs[i].hi;
            ram[vecs[i].pc + 12'd1] = vecs[i].lo;
            run_fetch(vecs[i].pc, vecs[i].exp_op);
            tick();
        end

        // Back-to-back: request held high, pc advanced on each valid pulse.
        ram[12'h300] = 8'h81; ram[12'h301] = 8'h24;
        ram[12'h302] = 8'hD0; ram[12'h303] = 8'h15;
        fetch_req = 1'b1;
        pc        = 12'h300;
        seen      = 0;
        t_first   = 0;
        t_second  = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (opcode_valid) begin
                seen++;
                if (seen == 1) begin
                    t_first = c;
                    chk("b2b_op1", {16'd0, opcode}, 32'h8124);
                    pc = 12'h302;
                end else if (seen == 2) begin
                    t_second = c;
                    chk("b2b_op2", {16'd0, opcode}, 32'hD015);
                    chk("b2b_pc2", {20'd0, opcode_pc}, 32'h302);
                    fetch_req = 1'b0;
                end
            end
        end
        fetch_req = 1'b0;
        chk("b2b_count", seen, 2);
        chk("b2b_first", t_first, 4);
        chk("b2b_gap", t_second - t_first, 4);

        // Request pulsed during RD_LO must be ignored.
        ram[12'h400] = 8'h99; ram[12'h401] = 8'h98;
        fetch_req = 1'b1;
        pc        = 12'h200;
        vcount    = 0;
        saw_400   = 1'b0;
        tick();
        fetch_req = 1'b0;
        tick();
        fetch_req = 1'b1;
        pc        = 12'h400;
        for (int c = 0; c < 10; c++) begin
            if (mem_rd && mem_addr == 12'h400) saw_400 = 1'b1;
            tick();
            fetch_req = 1'b0;
            if (opcode_valid) begin
                vcount++;
                chk("ign_oppc", {20'd0, opcode_pc}, 32'h200);
                chk("ign_op",   {16'd0, opcode}, 32'h6A2F);
            end
        end
        chk("ign_count", vcount, 1);
        chk("ign_no400", {31'd0, saw_400}, 32'd0);

        // Reset asserted in RD_LO abandons the fetch.
        ram[12'h202] = 8'hA2; ram[12'h203] = 8'hF0;
        fetch_req = 1'b1;
        pc        = 12'h200;
        tick();
        fetch_req = 1'b0;
        tick();
        chk("mid_in_rdlo", {20'd0, mem_addr}, 32'h201);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy",  {31'd0, busy},   32'd0);
        chk("mid_rd",    {31'd0, mem_rd}, 32'd0);
        chk("mid_op",    {16'd0, opcode}, 32'd0);
        chk("mid_oppc",  {20'd0, opcode_pc}, 32'd0);
        chk("mid_valid", {31'd0, opcode_valid}, 32'd0);
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (opcode_valid) vcount++;
        end
        chk("mid_novalid", vcount, 0);
        run_fetch(12'h202, 16'hA2F0);
        tick();

        // Reset together with a request: reset wins.
        reset     = 1'b1;
        fetch_req = 1'b1;
        pc        = 12'h300;
        tick();
        reset     = 1'b0;
        fetch_req = 1'b0;
        chk("rstreq_busy", {31'd0, busy}, 32'd0);
        chk("rstreq_rd",   {31'd0, mem_rd}, 32'd0);
        tick();
        chk("rstreq_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/chip8_fetch.md
# chip8_fetch

Instruction-fetch unit for the CHIP-8 core; it is the producer side of the 16-bit opcode interface that the instruction decoder consumes. On request, it reads two consecutive bytes from the 8-bit program RAM starting at the supplied PC. It assembles them big-endian into one opcode and presents it with a single-cycle valid strobe. It sits between the CPU control FSM (which owns PC) and the shared RAM read port.

## Interface
Parameters:
- ADDR_W, 12, RAM address width; all PC arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  request a fetch; sampled only in IDLE.
- pc  in  ADDR_W  address of opcode high byte; sampled with fetch_req.
- mem_rd  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address.
- mem_rdata  in  8  RAM read data, valid exactly one cycle after the mem_rd/mem_addr cycle.
- busy  out  1  high while a fetch is in flight (RD_HI, RD_LO, ASSEMBLE).
- opcode  out  16  last assembled opcode, {byte[pc], byte[pc+1]}; held until the next completion.
- opcode_pc  out  ADDR_W  PC the current opcode was fetched from; updates with opcode.
- opcode_valid  out  1  one-cycle pulse when opcode/opcode_pc update.

## Operation
- States: IDLE, RD_HI, RD_LO, ASSEMBLE.
- IDLE:
  - fetch_req=1: latch pc into pc_q and go to RD_HI.
  - fetch_req=0: stay in IDLE.
- RD_HI: mem_rd=1, mem_addr=pc_q; go to RD_LO.
- RD_LO:
  - Capture mem_rdata into hi_q.
  - Drive mem_rd=1, mem_addr=pc_q+1 (ADDR_W bits, wraps: pc_q=all-ones gives address 0).
  - Go to ASSEMBLE.
- ASSEMBLE:
  - mem_rd=0.
  - Register opcode={hi_q, mem_rdata}, opcode_pc=pc_q, opcode_valid=1.
  - Go to IDLE.
- opcode_valid is registered and deasserts the following cycle unconditionally.
- mem_rd=0 and mem_addr=pc_q outside RD_HI/RD_LO; mem_addr is don't-care when mem_rd=0 but must be stable.
- Odd PCs are legal; there is no alignment check.
- fetch_req while busy=1 is ignored: not queued, no error. The requester must hold or re-issue the request.
- pc changes while busy have no effect; pc_q is frozen.
- Reset values: state=IDLE, mem_rd=0, mem_addr=0, busy=0, opcode=16'h0000, opcode_pc=0, opcode_valid=0, hi_q=0.
- Reset mid-fetch: the fetch is abandoned and no opcode_valid is emitted. Outputs take reset values on the next edge. The first fetch_req after reset deasserts is accepted normally.
- Reset asserted together with fetch_req: reset wins.

## Timing
- Request accepted in IDLE at cycle N, where N is the edge at which fetch_req=1 is sampled.
- Sequence:
  - Cycle N+1: RD_HI.
  - Cycle N+2: RD_LO (hi byte arrives).
  - Cycle N+3: ASSEMBLE (lo byte arrives).
  - Cycle N+4: opcode, opcode_pc and opcode_valid=1 visible.
- Latency from request sample to opcode_valid: 4 cycles.
- Back-to-back throughput: the state is IDLE at cycle N+4, so a fetch_req held high is accepted at N+4. This gives one opcode per 4 cycles. opcode_valid of fetch k coincides with acceptance of fetch k+1.
- busy is high in cycles N+1..N+3 and low at N and N+4.
- mem_rd is high in exactly 2 cycles per fetch (N+1, N+2).
- No combinational path from any input to any output except none; all outputs are registered or decoded from registered state.

## Test plan
- Basic fetch:
  - Stimulus: RAM[0x200]=0x6A, RAM[0x201]=0x2F; fetch_req pulse with pc=0x200.
  - Required response: mem_addr 0x200 then 0x201 with mem_rd high 2 cycles. opcode=16'h6A2F, opcode_pc=0x200, opcode_valid high exactly 1 cycle, 4 cycles after the sample. busy high 3 cycles.
- Wrap-around:
  - Stimulus: RAM[0xFFF]=0x00, RAM[0x000]=0xE0; fetch pc=0xFFF.
  - Required response: second read at address 0x000. opcode=16'h00E0, opcode_pc=0xFFF.
- Back-to-back:
  - Stimulus: fetch_req held high, pc=0x300 then 0x302 (updated on each opcode_valid); RAM holds 0x8124, 0xD015.
  - Required response: opcodes 16'h8124 and 16'hD015 with opcode_valid pulses exactly 4 cycles apart. No dropped or duplicated fetch.
- Ignored request:
  - Stimulus: pulse fetch_req with pc=0x400 during RD_LO of a fetch from 0x200.
  - Required response: only one opcode_valid, opcode_pc=0x200. No read of 0x400.
- Reset mid-fetch:
  - Stimulus: assert reset in RD_LO.
  - Required response: next cycle all outputs at reset values (opcode=0, valid=0, busy=0, mem_rd=0). No opcode_valid afterwards. A subsequent fetch of 0x202 completes with the correct data.
- Odd PC:
  - Stimulus: fetch pc=0x205 with RAM[0x205]=0xF2, RAM[0x206]=0x33.
  - Required response: opcode=16'hF233.
